// File: rtl/tv_pkg.sv
// Shared encodings for the test-vector sequence generator.
// FSM states and pattern modes used by tv_seq_gen and its bench.
package tv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    MODE_BIN   = 2'b00,
    MODE_GRAY  = 2'b01,
    MODE_WALK1 = 2'b10,
    MODE_WALK0 = 2'b11
  } mode_e;

  // Walking patterns have N entries; counting patterns have 2^N.
  function automatic logic is_walk(mode_e m);
    return (m == MODE_WALK1) || (m == MODE_WALK0);
  endfunction

endpackage

// File: rtl/tv_seq_gen_tick_div.sv
// Hold-time divider: counts 1..step and pulses tick on the last count.
// A step of zero behaves as one; clr reloads the count to 1.
module tick_div #(
  parameter int STEP_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              clr,
  input  logic [STEP_W-1:0] step,
  output logic              tick
);

  logic [STEP_W-1:0] cnt;
  logic [STEP_W-1:0] lim;

  assign lim  = (step == '0) ? STEP_W'(1) : step;
  assign tick = en & ~clr & (cnt == lim);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= STEP_W'(1);
    end else if (clr || tick) begin
      cnt <= STEP_W'(1);
    end else if (en) begin
      cnt <= cnt + STEP_W'(1);
    end
  end

endmodule

// File: rtl/tv_seq_gen.sv
// Test-vector sequence generator: binary, Gray, walking-one/zero.
// Each vector is held step cycles; single pass or continuous wrap.
module tv_seq_gen
  import tv_pkg::*;
#(
  parameter int N_IN   = 2,
  parameter int STEP_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic [1:0]        mode,
  input  logic [STEP_W-1:0] step,
  input  logic              loop,
  output logic [N_IN-1:0]   vec,
  output logic              vec_valid,
  output logic              busy,
  output logic              done
);

  localparam int IW = N_IN;
  localparam logic [IW-1:0] LAST_CNT  = '1;
  localparam logic [IW-1:0] LAST_WALK = IW'(N_IN - 1);

  state_e            state;
  mode_e             mode_q;
  logic [STEP_W-1:0] step_q;
  logic              loop_q;
  logic [IW-1:0]     idx;

  logic              tick;
  logic              en;
  logic              clr;
  logic              wrap;
  logic [IW-1:0]     last;
  logic [IW-1:0]     idx_nxt;
  mode_e             map_mode;
  logic [IW-1:0]     map_idx;
  logic [IW-1:0]     mapped;

  assign en  = (state == ST_RUN);
  assign clr = (state != ST_RUN) | stop;

  tick_div #(
    .STEP_W(STEP_W)
  ) u_div (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .clr (clr),
    .step(step_q),
    .tick(tick)
  );

  always_comb begin
    last    = is_walk(mode_q) ? LAST_WALK : LAST_CNT;
    wrap    = (idx == last);
    idx_nxt = wrap ? '0 : idx + IW'(1);
  end

  // In IDLE the first vector comes from the live mode input,
  // since the latched copy is only written on that same edge.
  always_comb begin
    map_mode = (state == ST_RUN) ? mode_q : mode_e'(mode);
    map_idx  = (state == ST_RUN) ? idx_nxt : '0;
    mapped   = '0;
    unique case (map_mode)
      MODE_BIN:   mapped = map_idx;
      MODE_GRAY:  mapped = map_idx ^ (map_idx >> 1);
      MODE_WALK1: mapped = IW'(1) << map_idx;
      MODE_WALK0: mapped = ~(IW'(1) << map_idx);
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      mode_q    <= MODE_BIN;
      step_q    <= '0;
      loop_q    <= 1'b0;
      idx       <= '0;
      vec       <= '0;
      vec_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      vec_valid <= 1'b0;
      done      <= 1'b0;
      case (state)
        ST_IDLE: begin
          vec  <= '0;
          busy <= 1'b0;
          idx  <= '0;
          if (start && !stop) begin
            state     <= ST_RUN;
            mode_q    <= mode_e'(mode);
            step_q    <= step;
            loop_q    <= loop;
            vec       <= mapped;
            vec_valid <= 1'b1;
            busy      <= 1'b1;
          end
        end
        ST_RUN: begin
          if (stop) begin
            state <= ST_IDLE;
            vec   <= '0;
            busy  <= 1'b0;
            idx   <= '0;
          end else if (tick) begin
            if (wrap && !loop_q) begin
              state <= ST_DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
              vec   <= '0;
              idx   <= '0;
            end else begin
              idx       <= idx_nxt;
              vec       <= mapped;
              vec_valid <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          vec   <= '0;
          busy  <= 1'b0;
          idx   <= '0;
        end
        default: begin
          state <= ST_IDLE;
          vec   <= '0;
          busy  <= 1'b0;
          idx   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tv_seq_gen.sv
// Bench for tv_seq_gen: three widths driven in lockstep,
// checked by a timeline model plus directed tables and sequences.
module tb_tv_seq_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       stop;
  logic       loop;
  logic [1:0] mode;
  logic [7:0] step;

  logic [1:0] vec2;
  logic [2:0] vec3;
  logic [3:0] vec4;
  logic vv2, vv3, vv4;
  logic busy2, busy3, busy4;
  logic done2, done3, done4;

  always #5 clk = ~clk;

  tv_seq_gen #(.N_IN(2), .STEP_W(8)) u2 (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .mode(mode), .step(step), .loop(loop),
    .vec(vec2), .vec_valid(vv2), .busy(busy2), .done(done2)
  );

  tv_seq_gen #(.N_IN(3), .STEP_W(8)) u3 (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .mode(mode), .step(step), .loop(loop),
    .vec(vec3), .vec_valid(vv3), .busy(busy3), .done(done3)
  );

  tv_seq_gen #(.N_IN(4), .STEP_W(8)) u4 (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .mode(mode), .step(step), .loop(loop),
    .vec(vec4), .vec_valid(vv4), .busy(busy4), .done(done4)
  );

  int errors = 0;
  int checks = 0;

  // Model: phase 0 idle, 1 running, 2 done-pulse cycle.
  // t counts cycles since the first vector appeared.
  int nin[3] = '{2, 3, 4};
  int ph[3];
  int t[3];
  int ml[3];
  int hl[3];
  bit ll[3];

  function automatic int fmap(int n, int m, int i);
    int r;
    case (m)
      0:       r = i;
      1:       r = i ^ (i >> 1);
      2:       r = 1 << i;
      default: r = ~(1 << i);
    endcase
    return r & ((1 << n) - 1);
  endfunction

  function automatic int slen(int n, int m);
    return (m >= 2) ? n : (1 << n);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 3; k++) begin
      if (!rst) begin
        ph[k] = 0;
      end else begin
        case (ph[k])
          0: if (start && !stop) begin
            ph[k] = 1;
            t[k]  = 0;
            ml[k] = int'(mode);
            hl[k] = (step == 0) ? 1 : int'(step);
            ll[k] = loop;
          end
          1: if (stop) begin
            ph[k] = 0;
          end else begin
            t[k]++;
            if (!ll[k] && t[k] == slen(nin[k], ml[k]) * hl[k])
              ph[k] = 2;
          end
          default: ph[k] = 0;
        endcase
      end
    end
  endtask

  task automatic get_dut(input int k, output int av, output int avv,
                         output int ab, output int ad);
    case (k)
      0: begin av = vec2; avv = vv2; ab = busy2; ad = done2; end
      1: begin av = vec3; avv = vv3; ab = busy3; ad = done3; end
      default: begin av = vec4; avv = vv4; ab = busy4; ad = done4; end
    endcase
  endtask

  task automatic compare_model();
    int ev, evv, eb, ed;
    int av, avv, ab, ad;
    for (int k = 0; k < 3; k++) begin
      ev = 0; evv = 0; eb = 0; ed = 0;
      if (ph[k] == 1) begin
        ev  = fmap(nin[k], ml[k], (t[k] / hl[k]) % slen(nin[k], ml[k]));
        evv = (t[k] % hl[k] == 0) ? 1 : 0;
        eb  = 1;
      end else if (ph[k] == 2) begin
        ed = 1;
      end
      get_dut(k, av, avv, ab, ad);
      check($sformatf("model_u%0d_vec", nin[k]), av, ev);
      check($sformatf("model_u%0d_vv", nin[k]), avv, evv);
      check($sformatf("model_u%0d_busy", nin[k]), ab, eb);
      check($sformatf("model_u%0d_done", nin[k]), ad, ed);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_model();
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((ph[0] != 0 || ph[1] != 0 || ph[2] != 0) && n < 300) begin
      tick();
      n++;
    end
    check("wait_idle_bound", (ph[0] | ph[1] | ph[2]), 0);
  endtask

  typedef struct {
    logic start;
    int   vec;
    logic vv;
    logic busy;
    logic done;
  } row_t;

  row_t tab[10];

  initial begin
    int nv;
    int got_done;

    // N=3 Gray, step 1, single pass
    tab[0] = '{1'b1, 0, 1'b1, 1'b1, 1'b0};
    tab[1] = '{1'b0, 1, 1'b1, 1'b1, 1'b0};
    tab[2] = '{1'b0, 3, 1'b1, 1'b1, 1'b0};
    tab[3] = '{1'b0, 2, 1'b1, 1'b1, 1'b0};
    tab[4] = '{1'b0, 6, 1'b1, 1'b1, 1'b0};
    tab[5] = '{1'b0, 7, 1'b1, 1'b1, 1'b0};
    tab[6] = '{1'b0, 5, 1'b1, 1'b1, 1'b0};
    tab[7] = '{1'b0, 4, 1'b1, 1'b1, 1'b0};
    tab[8] = '{1'b0, 0, 1'b0, 1'b0, 1'b1};
    tab[9] = '{1'b0, 0, 1'b0, 1'b0, 1'b0};

    for (int k = 0; k < 3; k++) begin
      ph[k] = 0; t[k] = 0; ml[k] = 0; hl[k] = 1; ll[k] = 0;
    end

    rst = 1'b1; start = 1'b0; stop = 1'b0;
    loop = 1'b0; mode = 2'b00; step = 8'd1;
    #1 rst = 1'b0;
    tick();
    tick();
    check("reset_vec4", vec4, 0);
    check("reset_busy2", busy2, 0);
    rst = 1'b1;
    tick();

    // N=2 binary, step 5: vectors 0..3 then done 20 cycles in
    mode = 2'b00; step = 8'd5; loop = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    nv = 0;
    got_done = -1;
    for (int c = 0; c < 40; c++) begin
      if (vv2) begin
        check("r31_vec", vec2, nv);
        nv++;
      end
      if (done2) begin
        got_done = c;
        break;
      end
      tick();
    end
    check("r31_done_at", got_done, 20);
    check("r31_nvec", nv, 4);
    wait_idle();

    // Table: N=3 Gray sequence on consecutive cycles
    mode = 2'b01; step = 8'd1; loop = 1'b0;
    for (int i = 0; i < 10; i++) begin
      start = tab[i].start;
      tick();
      check($sformatf("r32_vec_%0d", i), vec3, tab[i].vec);
      check($sformatf("r32_vv_%0d", i), vv3, tab[i].vv);
      check($sformatf("r32_busy_%0d", i), busy3, tab[i].busy);
      check($sformatf("r32_done_%0d", i), done3, tab[i].done);
    end
    start = 1'b0;
    wait_idle();

    // N=4 walking-one loop, step 2; inputs changed mid-run
    mode = 2'b10; step = 8'd2; loop = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    mode = 2'b11; step = 8'd7; loop = 1'b0;
    for (int c = 0; c <= 12; c++) begin
      check($sformatf("r33_vec_%0d", c), vec4, 1 << ((c / 2) % 4));
      check($sformatf("r33_vv_%0d", c), vv4, (c % 2 == 0) ? 1 : 0);
      check($sformatf("r33_done_%0d", c), done4, 0);
      if (c != 12) begin
        start = (c == 5);
        tick();
      end
    end
    start = 1'b0;
    // stop while the third vector is showing
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("r35_vec", vec4, 0);
    check("r35_busy", busy4, 0);
    check("r35_done", done4, 0);
    tick();
    check("r35_done_after", done4, 0);

    // step 0 behaves as 1, walking-zero on N=2
    mode = 2'b11; step = 8'd0; loop = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    check("r34_v0", vec2, 2);
    check("r34_vv0", vv2, 1);
    tick();
    check("r34_v1", vec2, 1);
    check("r34_vv1", vv2, 1);
    tick();
    check("r34_done", done2, 1);
    check("r34_busy", busy2, 0);
    wait_idle();

    // start and stop together in IDLE stays idle
    start = 1'b1; stop = 1'b1;
    tick();
    check("ss_busy", busy2, 0);
    check("ss_vv", vv2, 0);
    start = 1'b0; stop = 1'b0;
    tick();

    // async reset mid-run, then restart from f(0)
    mode = 2'b00; step = 8'd3; loop = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("r36_pre_busy", busy4, 1);
    rst = 1'b0;
    #1;
    check("r36_vec4", vec4, 0);
    check("r36_busy4", busy4, 0);
    check("r36_vv3", vv3, 0);
    check("r36_done2", done2, 0);
    tick();
    tick();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("r36_no_done", done2, 0);
      check("r36_idle", busy2, 0);
    end
    mode = 2'b10; step = 8'd2; loop = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    check("r36_restart_vec", vec2, 1);
    check("r36_restart_vv", vv2, 1);
    check("r36_restart_busy", busy2, 1);
    wait_idle();

    // Randomized run against the timeline model
    for (int i = 0; i < 600; i++) begin
      start = ($urandom_range(0, 3) == 0);
      stop  = ($urandom_range(0, 23) == 0);
      mode  = 2'($urandom);
      step  = 8'($urandom_range(0, 3));
      loop  = 1'($urandom_range(0, 1));
      rst   = ($urandom_range(0, 79) != 0);
      tick();
    end
    rst = 1'b1; start = 1'b0; stop = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tv_seq_gen.md
TV_SEQ_GEN -- requirements
Module: tv_seq_gen

Interface
REQ-001 SHALL have parameter N_IN, default 2, meaning vector width (legal 1..8).
REQ-002 SHALL have parameter STEP_W, default 8, meaning width of the step input.
REQ-003 SHALL have port clk  input  1  single clock, all state rising-edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  level-sampled request to begin a sequence.
REQ-006 SHALL have port stop  input  1  abort running sequence.
REQ-007 SHALL have port mode  input  2  00 binary count, 01 Gray count, 10 walking-one, 11 walking-zero.
REQ-008 SHALL have port step  input  STEP_W  clk cycles each vector is held; 0 treated as 1.
REQ-009 SHALL have port loop  input  1  1 = wrap continuously, 0 = single pass.
REQ-010 SHALL have port vec  output  N_IN  current test vector.
REQ-011 SHALL have port vec_valid  output  1  one-cycle pulse on each new vector.
REQ-012 SHALL have port busy  output  1  high while sequence running.
REQ-013 SHALL have port done  output  1  one-cycle pulse at end of single pass.

Function
REQ-014 SHALL implement FSM IDLE, RUN, DONE; IDLE->RUN on start&!stop; RUN->IDLE on stop; RUN->DONE on final tick with loop=0; DONE->IDLE unconditionally next cycle.
REQ-015 SHALL latch mode, step, loop on the IDLE->RUN transition; changes during RUN ignored.
REQ-016 SHALL, one cycle after start is sampled, drive busy=1, vec=f(0), vec_valid=1.
REQ-017 SHALL hold each vector exactly max(step,1) cycles, then advance index and pulse vec_valid with the new vector.
REQ-018 SHALL use sequence length 2^N_IN for modes 00/01, N_IN for modes 10/11.
REQ-019 SHALL compute f(i): 00 -> i; 01 -> i ^ (i>>1); 10 -> one-hot bit i; 11 -> ~(one-hot bit i); all truncated to N_IN bits.
REQ-020 SHALL, with loop=1, wrap index from last to 0 without a gap cycle and without a done pulse.
REQ-021 SHALL, with loop=0, after the last vector's hold expires enter DONE: done=1, busy=0, vec=0, vec_valid=0 for that cycle.
REQ-022 SHALL, on stop in RUN, return to IDLE next cycle with vec=0, busy=0, no done pulse.
REQ-023 SHALL ignore start while in RUN or DONE; start and stop both high in IDLE SHALL remain in IDLE.
REQ-024 SHALL keep vec=0, busy=0, vec_valid=0, done=0 in IDLE.

Reset
REQ-025 SHALL, on rst low, asynchronously force state IDLE, index 0, divider count 1, vec=0, vec_valid=0, busy=0, done=0.
REQ-026 SHALL, on rst low mid-sequence, abandon the sequence; no done pulse on release.
REQ-027 SHALL resume in IDLE after rst release, requiring a new start.

Structure
REQ-028 SHALL place FSM state encodings and mode encodings in shared package tv_pkg.
REQ-029 SHALL instantiate one sub-module tick_div (counter 1..step, one-cycle tick, synchronous clear input for restart/stop).
REQ-030 SHALL keep vector mapping f(i) combinational from index and latched mode, registered onto vec.

Verification
REQ-031 SHALL verify N_IN=2, step=5, mode=00, loop=0 -> vec 00,01,10,11 each 5 cycles, done pulse 20 cycles after first vec_valid.
REQ-032 SHALL verify N_IN=3, step=1, mode=01 -> 000,001,011,010,110,111,101,100 on consecutive cycles, then done.
REQ-033 SHALL verify N_IN=4, step=2, mode=10, loop=1 -> 0001,0010,0100,1000,0001... every 2 cycles, no done pulse.
REQ-034 SHALL verify step=0, mode=11, N_IN=2 -> 10,01 one cycle each (behaves as step=1).
REQ-035 SHALL verify stop asserted during third vector -> next cycle vec=0, busy=0, done=0.
REQ-036 SHALL verify rst low mid-RUN -> outputs zero immediately; start after release restarts from f(0).
